// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel packet assembler.
//   state_t            : assembler FSM state encoding (also visible on the
//                        debug port of the top level)
//   START_BYTE_DEFAULT : default frame header byte
package pixel_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,  // hunting for the frame header byte
        CHAN    = 3'd1,  // collecting channel bytes of one pixel
        PIX_OUT = 3'd2,  // presenting an assembled pixel downstream
        CSUM    = 3'd3,  // waiting for the trailing checksum byte
        CAM     = 3'd4,  // camera-mode frame marker, one cycle
        ERR     = 3'd5   // timeout recovery, one cycle
    } state_t;

    localparam logic [7:0] START_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/timeout_counter.sv
// Idle-cycle watchdog for the pixel packet assembler.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : restart the count (a byte was consumed or the state moved)
//   en           : count this cycle (waiting on an empty FIFO)
//   expired      : count has reached LIMIT-1 while still enabled
module timeout_counter #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            // Saturate at LAST; the FSM leaves the waiting state anyway.
            count <= count + 1'b1;
        end
    end

    // A clearing cycle never reports expiry, so a stale count left over
    // from a previous visit to a waiting state cannot fire early.
    assign expired = en && !clr && (count == LAST);

endmodule

// File: rtl/pixel_packet_assembler.sv
// Pixel packet assembler: pulls bytes from a first-word-fall-through FIFO,
// finds the frame header, groups NUM_CH bytes per pixel and hands pixels
// downstream, then checks an optional trailing XOR checksum.
//   clk, reset_n        : clock, asynchronous active-low reset
//   empty, pop_data     : FIFO status and head byte
//   pop                 : consume the FIFO head this cycle
//   cam_mode            : 1 = camera source (header only), 0 = UART frame
//   pixel_data          : assembled pixel, first channel byte in the MSBs
//   pixel_valid/ready   : downstream pixel handshake
//   pixel_cnt           : pixels delivered in the current frame
//   frame_done/err      : single-cycle end-of-frame status pulses
//   busy                : assembler is inside a frame
//   dbg_state           : current FSM state
//
// Handshake: a pixel transfers on a rising edge where pixel_valid and
// pixel_ready are both 1. Once pixel_valid rises, pixel_data holds until that
// transfer; pixel_ready may toggle freely and may be low indefinitely.
// On the FIFO side a byte is consumed on every rising edge where pop is 1.
module pixel_packet_assembler
    import pixel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned NUM_CH          = 3,
    parameter int unsigned TOTAL_PIXELS    = 40800,
    parameter int unsigned PIXEL_CNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] START_BYTE = DATA_WIDTH'(START_BYTE_DEFAULT),
    parameter int unsigned CSUM_EN         = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            empty,
    input  logic [DATA_WIDTH-1:0]           pop_data,
    output logic                            pop,
    input  logic                            cam_mode,
    output logic [NUM_CH*DATA_WIDTH-1:0]    pixel_data,
    output logic                            pixel_valid,
    input  logic                            pixel_ready,
    output logic [PIXEL_CNT_WIDTH-1:0]      pixel_cnt,
    output logic                            frame_done,
    output logic                            frame_err,
    output logic                            busy,
    output state_t                          dbg_state
);

    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);
    localparam logic [PIXEL_CNT_WIDTH-1:0] LAST_PIX = PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1);

    state_t                 state;
    state_t                 state_prev;
    logic [1:0]             ch_idx;
    logic [DATA_WIDTH-1:0]  csum;
    logic                   tmo_clr;
    logic                   tmo_en;
    logic                   tmo_expired;

    // Only states that actually consume a byte may pop; reset_n gates pop so
    // nothing leaves the FIFO while reset is held.
    assign pop = reset_n && !empty &&
                 ((state == IDLE) || (state == CHAN) || (state == CSUM));

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // The watchdog runs only while waiting for bytes; PIX_OUT is excluded so a
    // downstream stall never aborts a frame.
    assign tmo_en  = empty && ((state == CHAN) || (state == CSUM));
    assign tmo_clr = pop || (state != state_prev);

    timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            state_prev  <= IDLE;
            ch_idx      <= '0;
            csum        <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_cnt   <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_prev <= state;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    // Non-header bytes are popped and dropped here.
                    if (pop && (pop_data == START_BYTE)) begin
                        if (cam_mode) begin
                            state <= CAM;
                        end else begin
                            state  <= CHAN;
                            ch_idx <= '0;
                            csum   <= '0;
                        end
                    end
                end

                CHAN: begin
                    if (tmo_expired) begin
                        state <= ERR;
                    end else if (pop) begin
                        for (int c = 0; c < int'(NUM_CH); c++) begin
                            if (ch_idx == 2'(c)) begin
                                pixel_data[(int'(NUM_CH) - 1 - c)*DATA_WIDTH +: DATA_WIDTH] <= pop_data;
                            end
                        end
                        csum <= csum ^ pop_data;
                        if (ch_idx == LAST_CH) begin
                            ch_idx      <= '0;
                            pixel_valid <= 1'b1;
                            state       <= PIX_OUT;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end
                end

                PIX_OUT: begin
                    if (pixel_ready) begin
                        pixel_valid <= 1'b0;
                        if (pixel_cnt == LAST_PIX) begin
                            // Count holds at its last value until the frame
                            // closes, so it never exceeds TOTAL_PIXELS-1.
                            if (CSUM_EN != 0) begin
                                state <= CSUM;
                            end else begin
                                frame_done <= 1'b1;
                                pixel_cnt  <= '0;
                                state      <= IDLE;
                            end
                        end else begin
                            pixel_cnt <= pixel_cnt + 1'b1;
                            state     <= CHAN;
                        end
                    end
                end

                CSUM: begin
                    if (tmo_expired) begin
                        state <= ERR;
                    end else if (pop) begin
                        if (pop_data == csum) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        pixel_cnt <= '0;
                        state     <= IDLE;
                    end
                end

                CAM: begin
                    frame_done <= 1'b1;
                    pixel_cnt  <= '0;
                    state      <= IDLE;
                end

                ERR: begin
                    frame_err <= 1'b1;
                    pixel_cnt <= '0;
                    ch_idx    <= '0;
                    csum      <= '0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_packet_assembler.sv
module tb_pixel_packet_assembler;

  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int TP  = 4;
  localparam int PCW = 16;
  localparam int TO  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic                 empty;
  logic [DW-1:0]        pop_data;
  logic                 pop;
  logic                 cam_mode;
  logic [NCH*DW-1:0]    pixel_data;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic [PCW-1:0]       pixel_cnt;
  logic                 frame_done;
  logic                 frame_err;
  logic                 busy;
  pixel_pkg::state_t    dbg_state;

  pixel_packet_assembler #(
    .DATA_WIDTH      (DW),
    .NUM_CH          (NCH),
    .TOTAL_PIXELS    (TP),
    .PIXEL_CNT_WIDTH (PCW),
    .START_BYTE      (8'hAA),
    .CSUM_EN         (1),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .empty       (empty),
    .pop_data    (pop_data),
    .pop         (pop),
    .cam_mode    (cam_mode),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_cnt   (pixel_cnt),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FIFO model (first-word fall-through) ----------------
  logic [DW-1:0] fifo_q[$];
  bit take;

  initial begin
    empty = 1'b1;
    pop_data = '0;
    forever begin
      @(negedge clk);
      take = pop;
      @(posedge clk);
      #2;
      if (take && fifo_q.size() > 0) void'(fifo_q.pop_front());
      empty = (fifo_q.size() == 0);
      pop_data = empty ? '0 : fifo_q[0];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [NCH*DW-1:0] got_q[$];
  logic [NCH*DW-1:0] exp_q[$];
  int done_cnt, err_cnt, valid_cnt, pop_cnt, both_cnt, long_cnt;
  int done_cyc, err_cyc, last_pop_cyc;
  bit prev_done, prev_err;

  initial begin
    prev_done = 0;
    prev_err = 0;
    forever begin
      @(negedge clk);
      if (pixel_valid && pixel_ready) got_q.push_back(pixel_data);
      if (pixel_valid) valid_cnt++;
      if (pop) begin pop_cnt++; last_pop_cyc = cyc; end
      if (frame_done) begin done_cnt++; done_cyc = cyc; if (prev_done) long_cnt++; end
      if (frame_err) begin err_cnt++; err_cyc = cyc; if (prev_err) long_cnt++; end
      if (frame_done && frame_err) both_cnt++;
      prev_done = frame_done;
      prev_err = frame_err;
    end
  end

  // ---------------- driver / check tasks ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] frame_bytes [12];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0; err_cnt = 0; valid_cnt = 0; pop_cnt = 0;
    done_cyc = -1; err_cyc = -1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic push_frame(input logic [DW-1:0] cs);
    push(8'hAA);
    for (int i = 0; i < 12; i++) push(frame_bytes[i]);
    push(cs);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while ((done_cnt + err_cnt) == 0 && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, (n < 300), 1);
    tick(3);
  endtask

  task automatic check_pixels(input string tag);
    logic [NCH*DW-1:0] g;
    check({tag, "_npix"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      check($sformatf("%s_pix%0d", tag, i), g, exp_q[i]);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [NCH*DW-1:0] snap;
  int n;

  initial begin
    frame_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                    8'h77, 8'h88, 8'h99, 8'hAB, 8'hCD, 8'hEF};
    exp_q = {24'h112233, 24'h445566, 24'h778899, 24'hABCDEF};
    // XOR of the 12 channel bytes above = 8'h98
    reset_n = 1'b0;
    cam_mode = 1'b0;
    pixel_ready = 1'b1;
    clear_mon();

    // Reset: outputs quiet, no pop even with a byte waiting.
    push(8'h00);
    tick(3);
    check("rst_pop", pop, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_cnt", pixel_cnt, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_data", pixel_data, 0);
    reset_n = 1'b1;
    tick(3);
    check("garbage_drained", fifo_q.size(), 0);
    check("garbage_idle", busy, 0);

    // Good UART frame.
    clear_mon();
    push_frame(8'h98);
    wait_end("f1_end");
    check_pixels("f1");
    check("f1_done", done_cnt, 1);
    check("f1_err", err_cnt, 0);
    check("f1_cnt", pixel_cnt, 0);
    check("f1_busy", busy, 0);

    // Corrupted checksum.
    clear_mon();
    push_frame(8'h99);
    wait_end("f2_end");
    check_pixels("f2");
    check("f2_err", err_cnt, 1);
    check("f2_done", done_cnt, 0);
    check("f2_cnt", pixel_cnt, 0);

    // Junk before header.
    clear_mon();
    push(8'h00);
    push(8'h55);
    push_frame(8'h98);
    wait_end("f3_end");
    check_pixels("f3");
    check("f3_done", done_cnt, 1);
    check("f3_fifo", fifo_q.size(), 0);

    // Camera mode: frame_done two cycles after the header pop.
    clear_mon();
    cam_mode = 1'b1;
    n = cyc;
    push(8'hAA);
    tick(6);
    check("cam_done", done_cnt, 1);
    check("cam_lat", done_cyc - n, 2);
    check("cam_valid", valid_cnt, 0);
    check("cam_fifo", fifo_q.size(), 0);
    cam_mode = 1'b0;

    // Timeout after two channel bytes: 16 empty cycles in CHAN, one ERR
    // cycle, then the registered pulse -> 18 cycles after the last pop.
    clear_mon();
    push(8'hAA);
    push(8'h11);
    push(8'h22);
    wait_end("to_end");
    check("to_err", err_cnt, 1);
    check("to_done", done_cnt, 0);
    check("to_lat", err_cyc - last_pop_cyc, 18);
    check("to_busy", busy, 0);
    clear_mon();
    push_frame(8'h98);
    wait_end("to_new_end");
    check_pixels("to_new");
    check("to_new_done", done_cnt, 1);

    // Downstream stall of 20 cycles in PIX_OUT.
    clear_mon();
    pixel_ready = 1'b0;
    push_frame(8'h98);
    n = 0;
    while (!pixel_valid && n < 50) begin tick(1); n++; end
    check("stall_valid_seen", (n < 50), 1);
    snap = pixel_data;
    pop_cnt = 0;
    tick(20);
    check("stall_data0", snap, 24'h112233);
    check("stall_data", pixel_data, 24'h112233);
    check("stall_pops", pop_cnt, 0);
    check("stall_fifo", fifo_q.size(), 10);
    check("stall_err", err_cnt, 0);
    check("stall_valid", pixel_valid, 1);
    pixel_ready = 1'b1;
    wait_end("stall_end");
    check_pixels("stall");
    check("stall_done", done_cnt, 1);

    // Reset in the middle of a frame.
    clear_mon();
    push(8'hAA);
    push(8'h11);
    tick(4);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_async_idle", busy, 0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("mid_err", err_cnt, 0);
    check("mid_cnt", pixel_cnt, 0);
    check("mid_valid", pixel_valid, 0);
    clear_mon();
    push_frame(8'h98);
    wait_end("mid_new_end");
    check_pixels("mid_new");
    check("mid_new_done", done_cnt, 1);

    check("never_both", both_cnt, 0);
    check("single_cycle_pulses", long_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
